// File: rtl/seq_detector_param.sv
// rtl/seq_detector_param.sv - programmable serial bit-pattern detector with saturating match count
module seq_detector_param #(
  parameter int MAX_LEN = 8,
  parameter int CNT_W = 8,
  parameter logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(8'b0000_1011),
  parameter int DEF_LEN = 4,
  parameter int DEF_OVERLAP = 1,
  localparam int LEN_W = $clog2(MAX_LEN + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in,
  input  logic               in_valid,
  input  logic               load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               out,
  output logic [CNT_W-1:0]   match_count,
  output logic               cfg_err
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] DEF_LEN_L = LEN_W'(DEF_LEN);
  localparam logic DEF_ERR = (DEF_LEN == 0) || (DEF_LEN > MAX_LEN);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic               err_q, err_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               out_q, out_d;

  logic [MAX_LEN-1:0] mask;
  logic [MAX_LEN-1:0] nh;
  logic [LEN_W-1:0]   nf;
  logic               hit;

  always_comb begin
    mask = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len_q);
    end
    nh  = {hist_q[MAX_LEN-2:0], in};
    nf  = (fill_q >= MAX_LEN_L) ? MAX_LEN_L : fill_q + 1'b1;
    // fill gate keeps zeroed history from producing a false match
    hit = !err_q && (nf >= len_q) && (((nh ^ pat_q) & mask) == '0);
  end

  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    ovl_d  = ovl_q;
    err_d  = err_q;
    hist_d = hist_q;
    fill_d = fill_q;
    cnt_d  = cnt_q;
    out_d  = 1'b0;
    if (load) begin
      pat_d  = cfg_pattern;
      len_d  = cfg_len;
      ovl_d  = cfg_overlap;
      err_d  = (cfg_len == '0) || (cfg_len > MAX_LEN_L);
      hist_d = '0;
      fill_d = '0;
      cnt_d  = '0;
    end else if (in_valid) begin
      out_d = hit;
      if (hit && !(&cnt_q)) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (hit && !ovl_q) begin
        hist_d = '0;
        fill_d = '0;
      end else begin
        hist_d = nh;
        fill_d = nf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q  <= DEF_PATTERN;
      len_q  <= DEF_LEN_L;
      ovl_q  <= (DEF_OVERLAP != 0);
      err_q  <= DEF_ERR;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      out_q  <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      len_q  <= len_d;
      ovl_q  <= ovl_d;
      err_q  <= err_d;
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
    end
  end

  assign out         = out_q;
  assign match_count = cnt_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// tb/tb_seq_detector_param.sv - scoreboard bench for seq_detector_param
module tb_seq_detector_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       a_in, a_vld, a_ld, a_ovl;
  logic [7:0] a_pat;
  logic [3:0] a_len;
  logic       a_out, a_err;
  logic [7:0] a_cnt;
  logic       b_in, b_vld, b_ld, b_ovl;
  logic [7:0] b_pat;
  logic [3:0] b_len;
  logic       b_out, b_err;
  logic [1:0] b_cnt;

  seq_detector_param dut_a (
    .clk(clk), .reset(reset), .in(a_in), .in_valid(a_vld), .load(a_ld),
    .cfg_pattern(a_pat), .cfg_len(a_len), .cfg_overlap(a_ovl),
    .out(a_out), .match_count(a_cnt), .cfg_err(a_err)
  );

  seq_detector_param #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .in(b_in), .in_valid(b_vld), .load(b_ld),
    .cfg_pattern(b_pat), .cfg_len(b_len), .cfg_overlap(b_ovl),
    .out(b_out), .match_count(b_cnt), .cfg_err(b_err)
  );

  typedef struct {
    int         step;
    logic       chk_a;
    logic       out_a;
    logic [7:0] cnt_a;
    logic       err_a;
    logic       chk_b;
    logic       out_b;
    logic [1:0] cnt_b;
    logic       err_b;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   step_no = 0;

  task automatic chk(input string name, input int step, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s step=%0d got=%0d want=%0d", name, step, act, want);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.chk_a) begin
        chk("a_out", e.step, int'(a_out), int'(e.out_a));
        chk("a_count", e.step, int'(a_cnt), int'(e.cnt_a));
        chk("a_cfg_err", e.step, int'(a_err), int'(e.err_a));
      end
      if (e.chk_b) begin
        chk("b_out", e.step, int'(b_out), int'(e.out_b));
        chk("b_count", e.step, int'(b_cnt), int'(e.cnt_b));
        chk("b_cfg_err", e.step, int'(b_err), int'(e.err_b));
      end
    end
  end

  task automatic push(input logic ca, input logic oa, input logic [7:0] na, input logic ea,
                      input logic cb, input logic ob, input logic [1:0] nb, input logic eb);
    exp_t e;
    step_no++;
    e.step = step_no;
    e.chk_a = ca; e.out_a = oa; e.cnt_a = na; e.err_a = ea;
    e.chk_b = cb; e.out_b = ob; e.cnt_b = nb; e.err_b = eb;
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    reset = 1'b0;
    a_ld = 1'b0; a_vld = 1'b0; a_in = 1'b0;
    b_ld = 1'b0; b_vld = 1'b0; b_in = 1'b0;
  endtask

  task automatic reset_all();
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    push(1'b1, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic load_a(input logic [7:0] pat, input logic [3:0] len, input logic ovl, input logic ee);
    @(negedge clk);
    idle_inputs();
    a_ld = 1'b1; a_pat = pat; a_len = len; a_ovl = ovl;
    push(1'b1, 1'b0, 8'd0, ee, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic bit_a(input logic v, input logic b, input logic eo, input logic [7:0] ec, input logic ee);
    @(negedge clk);
    idle_inputs();
    a_vld = v; a_in = b;
    push(1'b1, eo, ec, ee, 1'b0, 1'b0, 2'd0, 1'b0);
  endtask

  task automatic step_b(input logic ld, input logic v, input logic b,
                        input logic [7:0] pat, input logic [3:0] len,
                        input logic eo, input logic [1:0] ec);
    @(negedge clk);
    idle_inputs();
    b_ld = ld; b_vld = v; b_in = b; b_pat = pat; b_len = len; b_ovl = 1'b1;
    push(1'b0, 1'b0, 8'd0, 1'b0, 1'b1, eo, ec, 1'b0);
  endtask

  initial begin
    logic [7:0] a5;
    reset = 1'b1;
    a_in = 1'b0; a_vld = 1'b0; a_ld = 1'b0; a_pat = '0; a_len = '0; a_ovl = 1'b0;
    b_in = 1'b0; b_vld = 1'b0; b_ld = 1'b0; b_pat = '0; b_len = '0; b_ovl = 1'b0;

    reset_all();
    reset_all();

    // default 1011, overlap: stream 1,1,0,1,1,1,1,0,0
    bit_a(1, 1, 0, 8'd0, 0);
    bit_a(1, 1, 0, 8'd0, 0);
    bit_a(1, 0, 0, 8'd0, 0);
    bit_a(1, 1, 0, 8'd0, 0);
    bit_a(1, 1, 1, 8'd1, 0);
    bit_a(1, 1, 0, 8'd1, 0);
    bit_a(1, 1, 0, 8'd1, 0);
    bit_a(1, 0, 0, 8'd1, 0);
    bit_a(1, 0, 0, 8'd1, 0);

    // 101 overlapping on 1,0,1,0,1
    load_a(8'b101, 4'd3, 1'b1, 1'b0);
    bit_a(1, 1, 0, 8'd0, 0);
    bit_a(1, 0, 0, 8'd0, 0);
    bit_a(1, 1, 1, 8'd1, 0);
    bit_a(1, 0, 0, 8'd1, 0);
    bit_a(1, 1, 1, 8'd2, 0);

    // 101 non-overlapping on 1,0,1,0,1
    load_a(8'b101, 4'd3, 1'b0, 1'b0);
    bit_a(1, 1, 0, 8'd0, 0);
    bit_a(1, 0, 0, 8'd0, 0);
    bit_a(1, 1, 1, 8'd1, 0);
    bit_a(1, 0, 0, 8'd1, 0);
    bit_a(1, 1, 0, 8'd1, 0);

    // 1011 with three idle cycles between bits
    load_a(8'b1011, 4'd4, 1'b1, 1'b0);
    bit_a(1, 1, 0, 8'd0, 0);
    repeat (3) bit_a(0, 1, 0, 8'd0, 0);
    bit_a(1, 0, 0, 8'd0, 0);
    repeat (3) bit_a(0, 1, 0, 8'd0, 0);
    bit_a(1, 1, 0, 8'd0, 0);
    repeat (3) bit_a(0, 0, 0, 8'd0, 0);
    bit_a(1, 1, 1, 8'd1, 0);
    repeat (2) bit_a(0, 1, 0, 8'd1, 0);

    // reset mid-pattern, then 0,1,1 must not complete 1011
    bit_a(1, 1, 0, 8'd1, 0);
    reset_all();
    bit_a(1, 0, 0, 8'd0, 0);
    bit_a(1, 1, 0, 8'd0, 0);
    bit_a(1, 1, 0, 8'd0, 0);

    // invalid lengths 0 and MAX_LEN+1
    load_a(8'h00, 4'd0, 1'b1, 1'b1);
    repeat (3) bit_a(1, 0, 0, 8'd0, 1);
    load_a(8'h01, 4'd9, 1'b1, 1'b1);
    repeat (9) bit_a(1, 1, 0, 8'd0, 1);

    // full-length pattern A5 sent MSB-first
    load_a(8'hA5, 4'd8, 1'b1, 1'b0);
    a5 = 8'hA5;
    for (int i = 7; i >= 1; i--) bit_a(1, a5[i], 0, 8'd0, 0);
    bit_a(1, a5[0], 1, 8'd1, 0);
    bit_a(0, 0, 0, 8'd1, 0);

    // 2-bit counter saturation with len=1
    step_b(1, 0, 0, 8'b1, 4'd1, 0, 2'd0);
    step_b(0, 1, 1, 8'b1, 4'd1, 1, 2'd1);
    step_b(0, 1, 1, 8'b1, 4'd1, 1, 2'd2);
    step_b(0, 1, 1, 8'b1, 4'd1, 1, 2'd3);
    repeat (5) step_b(0, 1, 1, 8'b1, 4'd1, 1, 2'd3);
    // load with a valid bit on the same edge: bit is dropped, count cleared
    step_b(1, 1, 1, 8'b11, 4'd2, 0, 2'd0);
    step_b(0, 1, 1, 8'b11, 4'd2, 0, 2'd0);
    step_b(0, 1, 1, 8'b11, 4'd2, 1, 2'd1);
    step_b(0, 0, 0, 8'b11, 4'd2, 0, 2'd1);

    @(negedge clk);
    idle_inputs();
    repeat (4) @(posedge clk);
    #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
